// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// pipeline MEM stage and a fixed-latency line memory (req/ack handshake).
// Raises busy to stall the pipeline while a fill or write-through is in
// flight and serves the re-presented request from the cache afterwards.
module data_cache_controller #(
  parameter int INDEX_BITS = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [15:0]          req_addr,
  input  logic [15:0]          req_wdata,
  output logic [15:0]          req_rdata,
  output logic                 busy,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [15:0]          mem_addr,
  output logic [15:0]          mem_wdata,
  input  logic [63:0]          mem_rdata,
  input  logic                 mem_ack,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 16 - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e                 state_q, state_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [TAG_W-1:0]       tag_d  [LINES];
  logic [3:0][15:0]       line_q [LINES];
  logic [3:0][15:0]       line_d [LINES];
  logic [15:0]            addr_q, addr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic                   replay_q, replay_d;
  logic                   rtype_q, rtype_d;   // 1 = latched op was a write
  logic [CNT_WIDTH-1:0]   hit_q, hit_d;
  logic [CNT_WIDTH-1:0]   miss_q, miss_d;

  logic [INDEX_BITS-1:0]  req_idx, lat_idx;
  logic [TAG_W-1:0]       req_tag, lat_tag;
  logic [1:0]             req_off, lat_off;
  logic                   req_hit, lat_hit, replay_match;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign req_off = req_addr[1:0];
  assign req_idx = req_addr[INDEX_BITS+1:2];
  assign req_tag = req_addr[15:INDEX_BITS+2];
  assign lat_off = addr_q[1:0];
  assign lat_idx = addr_q[INDEX_BITS+1:2];
  assign lat_tag = addr_q[15:INDEX_BITS+2];

  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  // The stalled pipeline re-presents the finished request once; a write
  // matches on the exact word, a read on the filled line (and must now hit).
  assign replay_match = replay_q &&
                        (req_write ? (rtype_q && (req_addr == addr_q))
                                   : (req_read && !rtype_q &&
                                      (req_addr[15:2] == addr_q[15:2]) && req_hit));

  // Next-state, line updates, counters and combinational busy/rdata.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    line_d      = line_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    replay_d    = replay_q;
    rtype_d     = rtype_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    busy        = 1'b0;
    req_rdata   = '0;
    case (state_q)
      IDLE: begin
        replay_d = 1'b0;
        if (replay_match) begin
          if (!req_write) req_rdata = line_q[req_idx][req_off];
        end else if (req_write) begin
          busy        = 1'b1;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          rtype_d     = 1'b1;
          mem_write_d = 1'b1;
          state_d     = WRITE;
          if (req_hit) hit_d  = sat_inc(hit_q);
          else         miss_d = sat_inc(miss_q);
        end else if (req_read) begin
          if (req_hit) begin
            req_rdata = line_q[req_idx][req_off];
            hit_d     = sat_inc(hit_q);
          end else begin
            busy       = 1'b1;
            addr_d     = {req_addr[15:2], 2'b00};
            rtype_d    = 1'b0;
            mem_read_d = 1'b1;
            miss_d     = sat_inc(miss_q);
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        busy = 1'b1;
        if (mem_ack) begin
          valid_d[lat_idx] = 1'b1;
          tag_d[lat_idx]   = lat_tag;
          line_d[lat_idx]  = mem_rdata;
          replay_d         = 1'b1;
          mem_read_d       = 1'b0;
          state_d          = IDLE;
        end
      end
      WRITE: begin
        busy = 1'b1;
        if (mem_ack) begin
          if (lat_hit) line_d[lat_idx][lat_off] = wdata_q;
          replay_d    = 1'b1;
          mem_write_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and memory-interface registers; reset abandons any transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      replay_q    <= 1'b0;
      rtype_q     <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      replay_q    <= replay_d;
      rtype_q     <= rtype_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  // Tag and data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: doc/data_cache_controller.md
Name: data_cache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate data cache that sits between the pipeline MEM stage and data memory.
- It is the source of the `DataCacheBusy` stall signal consumed by the pipeline control unit.
- It answers the pipeline's `DataMemRead`/`DataMemWrite` requests and runs line fills and word write-throughs to a fixed-latency memory using a req/ack handshake.
- It keeps hit and miss statistics.

Parameters:
- INDEX_BITS, 2, number of cache-index bits; lines = 2^INDEX_BITS, 4 x 16-bit words per line.
- CNT_WIDTH, 16, width of the hit and miss counters.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_read  input  1  pipeline load request (`DataMemRead`).
- req_write  input  1  pipeline store request (`DataMemWrite`).
- req_addr  input  16  word address.
- req_wdata  input  16  store data.
- req_rdata  output  16  load data; valid when req_read=1 and busy=0.
- busy  output  1  stall request to pipeline control (`DataCacheBusy`).
- mem_read  output  1  line-fill request to memory.
- mem_write  output  1  word-write request to memory.
- mem_addr  output  16  memory address; line-aligned (bits [1:0]=0) for fills, word address for writes.
- mem_wdata  output  16  memory write data.
- mem_rdata  input  64  fill data; word k in bits [16k+15:16k].
- mem_ack  input  1  one-cycle completion pulse from memory.
- hit_count  output  CNT_WIDTH  saturating count of hits.
- miss_count  output  CNT_WIDTH  saturating count of misses.

Behaviour:
- Address split: offset = addr[1:0]; index = addr[INDEX_BITS+1:2]; tag = addr[15:INDEX_BITS+2]. Each line holds valid, tag and 4 data words.
- Reset (async, reset_n=0):
  - all valid bits = 0; state = IDLE.
  - mem_read = mem_write = 0; mem_addr = mem_wdata = 0.
  - counters = 0; replay flag = 0.
  - busy = 0; req_rdata = 0.
  - Reset during FILL or WRITE abandons the operation with no line update; a later mem_ack is ignored.
- FSM states: IDLE, FILL, WRITE.
- IDLE, read hit (valid and tag match):
  - req_rdata = line word[offset], combinational, same cycle.
  - busy = 0.
  - hit_count++ unless replay.
- IDLE, read miss:
  - busy = 1 combinationally that cycle.
  - Latch line-aligned address; miss_count++.
  - Next state FILL.
- IDLE, write (write wins if req_read and req_write are both 1):
  - busy = 1.
  - Latch addr and wdata.
  - Count a hit if the line hits, a miss otherwise (suppressed on replay).
  - Next state WRITE.
- FILL:
  - mem_read = 1 (registered) and mem_addr = latched address, held until mem_ack.
  - busy = 1 through the mem_ack cycle.
  - On mem_ack: write line data, tag, valid=1; set replay; next state IDLE.
- WRITE:
  - mem_write = 1 with latched address and data, held until mem_ack.
  - busy = 1 through the mem_ack cycle.
  - On mem_ack: if the latched address hits, update that word in the cache (no allocate on miss); set replay; next state IDLE.
- Replay:
  - The pipeline holds its request stable while stalled, so the first IDLE cycle after completion re-presents the finished request.
  - If replay=1 and the request matches the latched address and type:
    - a write completes with busy = 0 and no new memory access;
    - a read serves from the cache (it now hits) with busy = 0.
  - In both cases the hit/miss counters are not updated.
  - replay clears after that IDLE cycle regardless of match.
- No request in IDLE: busy = 0, no state change, req_rdata = 0.
- mem_ack while IDLE is ignored.
- mem_ack arriving in the same cycle mem_read/mem_write first rises is not possible (memory latency >= 1 cycle after the request is seen).
- Counters saturate at all-ones.
- Stall cost:
  - read miss: busy for (1 + L) cycles, where L = cycles from mem_read high to mem_ack inclusive;
  - write: busy for (1 + L) cycles.

Test Plan:
- Reset, then read 0x0010 with memory latency 4 and mem_rdata = {16'hD,16'hC,16'hB,16'hA} -> busy = 1 for 5 cycles; mem_addr = 0x0010; then req_rdata = 0x000A with busy = 0; miss_count = 1, hit_count = 0.
- Same line, reads of 0x0011 then 0x0013 -> each takes 1 cycle with busy = 0; rdata = 0x000B then 0x000D; hit_count = 2.
- Write 0x0012 = 0xBEEF (hit) -> mem_write with mem_addr = 0x0012, mem_wdata = 0xBEEF; busy until mem_ack; the following read of 0x0012 returns 0xBEEF in 1 cycle.
- Write 0x0400 (miss) -> memory is written but the line is not allocated; the next read of 0x0400 misses and issues mem_read at 0x0400.
- Conflict: read 0x0010, then read 0x0050 (same index, different tag), then read 0x0010 -> three fills; miss_count = 3.
- Assert reset_n = 0 mid-FILL -> mem_read drops immediately; a late mem_ack is ignored; the next read of the same address misses.
